// File: rtl/peripheral_stats_reader.sv
// peripheral_stats_reader
// Initiator on the peripheral register block's cs request port. A start pulse
// launches a fixed readout. For each statistics word the block writes the word's
// index to STATS_ADDR and then reads STATS_ADDR. It then reads the three cache
// comm words. Each returned word is tagged and pushed into a first-word-fall-
// through FIFO, which feeds the host link over a valid/ready handshake.
//
// Ports:
//   clock_i       system clock
//   reset_i       asynchronous active-low reset
//   start_i       one-cycle start request (ignored while busy)
//   clear_i       synchronous abort plus FIFO flush (highest priority)
//   busy_o        sequence in progress
//   done_o        one-cycle pulse at sequence end
//   req_cs_o      one-cycle request strobe to the peripheral
//   rw_cs_o       1 = write, 0 = read
//   add_cs_o      request address (held between requests)
//   data_cs_o     write data (held between requests)
//   data_cs_i     peripheral read data, valid the cycle after the read request
//   word_valid_o  FIFO head valid
//   word_ready_i  consumer accepts head
//   word_data_o   FIFO head data
//   word_tag_o    FIFO head tag (0..N_STATS-1 stats, N_STATS..N_STATS+2 cache)
//   fifo_count_o  exact FIFO occupancy

`ifndef STATS_BASE
`define STATS_BASE 27'h000_0100
`endif
`ifndef COMM_CACHE0
`define COMM_CACHE0 27'h000_0200
`endif
`ifndef COMM_CACHE1
`define COMM_CACHE1 27'h000_0204
`endif
`ifndef COMM_CACHE2
`define COMM_CACHE2 27'h000_0208
`endif

module peripheral_stats_reader #(
    parameter int          N_STATS     = 6,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [26:0] STATS_ADDR  = `STATS_BASE,
    parameter logic [26:0] CACHE0_ADDR = `COMM_CACHE0,
    parameter logic [26:0] CACHE1_ADDR = `COMM_CACHE1,
    parameter logic [26:0] CACHE2_ADDR = `COMM_CACHE2
) (
    input  logic                            clock_i,
    input  logic                            reset_i,
    input  logic                            start_i,
    input  logic                            clear_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            req_cs_o,
    output logic                            rw_cs_o,
    output logic [26:0]                     add_cs_o,
    output logic [31:0]                     data_cs_o,
    input  logic [31:0]                     data_cs_i,
    output logic                            word_valid_o,
    input  logic                            word_ready_i,
    output logic [31:0]                     word_data_o,
    output logic [3:0]                      word_tag_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_o
);

    localparam int              PTR_W     = $clog2(FIFO_DEPTH);
    localparam int              CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [3:0]      N_STATS_K = 4'(N_STATS);
    localparam logic [3:0]      LAST_K    = 4'(N_STATS + 2);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        CAP  = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [3:0]        k_r, k_s;
    logic              wait_r, wait_s;      // CAP holding for FIFO space
    logic              pend_r, pend_s;      // start accepted, FIFO was full
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              req_r, req_s;
    logic              rw_r, rw_s;
    logic [26:0]       add_r, add_s;
    logic [31:0]       wdata_r, wdata_s;
    logic              launch_s;
    logic [3:0]        launch_k_s;
    logic              push_s, pop_s;
    logic              fifo_full_s;
    logic [CNT_W-1:0]  count_after_push_s;

    logic [31:0]       mem_data_r [FIFO_DEPTH];
    logic [3:0]        mem_tag_r  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  count_r, count_s;
    logic              valid_r;

    // Read address for word k: stats window for stats words, else cache word.
    function automatic logic [26:0] read_addr(input logic [3:0] k);
        logic [3:0] ci;
        ci = k - N_STATS_K;
        if (k < N_STATS_K) begin
            read_addr = STATS_ADDR;
        end else begin
            case (ci)
                4'd0:    read_addr = CACHE0_ADDR;
                4'd1:    read_addr = CACHE1_ADDR;
                default: read_addr = CACHE2_ADDR;
            endcase
        end
    endfunction

    assign pop_s       = valid_r & word_ready_i;
    assign fifo_full_s = (count_r == FULL_CNT);
    // Occupancy after this cycle's capture; only one word is ever in flight.
    assign count_after_push_s = pop_s ? count_r : (count_r + CNT_W'(1));

    // Next-state, next-request and FIFO push decode.
    always_comb begin
        state_s    = state_r;
        k_s        = k_r;
        wait_s     = wait_r;
        pend_s     = pend_r;
        req_s      = 1'b0;
        rw_s       = rw_r;
        add_s      = add_r;
        wdata_s    = wdata_r;
        done_s     = 1'b0;
        push_s     = 1'b0;
        launch_s   = 1'b0;
        launch_k_s = k_r;

        case (state_r)
            IDLE: begin
                if (start_i || pend_r) begin
                    k_s = 4'd0;
                    if (!fifo_full_s) begin
                        pend_s     = 1'b0;
                        launch_s   = 1'b1;
                        launch_k_s = 4'd0;
                    end else begin
                        pend_s = 1'b1;
                    end
                end else begin
                    pend_s = 1'b0;
                end
            end
            WR: begin
                state_s = RD;
                req_s   = 1'b1;
                rw_s    = 1'b0;
                add_s   = STATS_ADDR;
            end
            RD: begin
                state_s = CAP;
                wait_s  = 1'b0;
            end
            CAP: begin
                if (!wait_r) begin
                    push_s = 1'b1;
                    if (k_r == LAST_K) begin
                        state_s = FIN;
                        done_s  = 1'b1;
                    end else begin
                        k_s = k_r + 4'd1;
                        if (count_after_push_s < FULL_CNT) begin
                            launch_s   = 1'b1;
                            launch_k_s = k_r + 4'd1;
                        end else begin
                            wait_s = 1'b1;
                        end
                    end
                end else begin
                    if (!fifo_full_s) begin
                        wait_s     = 1'b0;
                        launch_s   = 1'b1;
                        launch_k_s = k_r;
                    end else begin
                        wait_s = 1'b1;
                    end
                end
            end
            FIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Word start: stats words begin with an index write, cache words with a read.
        if (launch_s) begin
            req_s = 1'b1;
            if (launch_k_s < N_STATS_K) begin
                state_s = WR;
                rw_s    = 1'b1;
                add_s   = STATS_ADDR;
                wdata_s = {29'b0, launch_k_s[2:0]};
            end else begin
                state_s = RD;
                rw_s    = 1'b0;
                add_s   = read_addr(launch_k_s);
            end
        end else begin
            req_s = req_s;
        end

        if (clear_i) begin
            state_s = IDLE;
            k_s     = 4'd0;
            wait_s  = 1'b0;
            pend_s  = 1'b0;
            req_s   = 1'b0;
            done_s  = 1'b0;
            push_s  = 1'b0;
        end else begin
            push_s = push_s;
        end

        busy_s = pend_s || (state_s == WR) || (state_s == RD) || (state_s == CAP);
    end

    // FIFO occupancy update.
    always_comb begin
        count_s = count_r;
        if (clear_i) begin
            count_s = '0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_s = count_r + CNT_W'(1);
                2'b01:   count_s = count_r - CNT_W'(1);
                default: count_s = count_r;
            endcase
        end
    end

    // FSM state and registered request/status outputs.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r <= IDLE;
            k_r     <= 4'd0;
            wait_r  <= 1'b0;
            pend_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            req_r   <= 1'b0;
            rw_r    <= 1'b0;
            add_r   <= 27'd0;
            wdata_r <= 32'd0;
        end else begin
            state_r <= state_s;
            k_r     <= k_s;
            wait_r  <= wait_s;
            pend_r  <= pend_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            req_r   <= req_s;
            rw_r    <= rw_s;
            add_r   <= add_s;
            wdata_r <= wdata_s;
        end
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_r[i] <= 32'd0;
                mem_tag_r[i]  <= 4'd0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= 1'b0;
        end else if (clear_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= 1'b0;
        end else begin
            if (push_s) begin
                mem_data_r[wr_ptr_r] <= data_cs_i;
                mem_tag_r[wr_ptr_r]  <= k_r;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_s;
            valid_r <= (count_s != '0);
        end
    end

    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign req_cs_o     = req_r;
    assign rw_cs_o      = rw_r;
    assign add_cs_o     = add_r;
    assign data_cs_o    = wdata_r;
    assign word_valid_o = valid_r;
    assign word_data_o  = mem_data_r[rd_ptr_r];
    assign word_tag_o   = mem_tag_r[rd_ptr_r];
    assign fifo_count_o = count_r;

endmodule
